// File: rtl/counter_bank.sv
// Bank of independent up/down counters with per-channel clear/load, optional
// saturation, overflow/underflow flagging (pulse or sticky) and compare-match pulse.
module counter_bank #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SATURATE        = 0,
    parameter int unsigned STICKY_OVERFLOW = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       clear_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       down_i,
    input  logic [NUM_CH*WIDTH-1:0] delta_i,
    input  logic [NUM_CH*WIDTH-1:0] d_i,
    input  logic [NUM_CH*WIDTH-1:0] cmp_i,
    output logic [NUM_CH*WIDTH-1:0] q_o,
    output logic [NUM_CH-1:0]       overflow_o,
    output logic [NUM_CH-1:0]       match_o,
    output logic                    any_overflow_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] q_r;
        logic [WIDTH-1:0] q_nxt;
        logic [WIDTH-1:0] dlt;
        logic [WIDTH-1:0] dval;
        logic [WIDTH-1:0] cval;
        logic [WIDTH:0]   sum;
        logic             ovf_r;
        logic             ovf_nxt;
        logic             match_r;
        logic             match_nxt;
        logic             upd;
        logic             evt;

        assign dlt  = delta_i[c*WIDTH +: WIDTH];
        assign dval = d_i[c*WIDTH +: WIDTH];
        assign cval = cmp_i[c*WIDTH +: WIDTH];
        assign sum  = {1'b0, q_r} + {1'b0, dlt};

        // Next count, event detection and flag update; clear > load > count > hold
        always_comb begin
            q_nxt     = q_r;
            evt       = 1'b0;
            upd       = 1'b0;
            ovf_nxt   = 1'b0;
            match_nxt = 1'b0;
            if (clear_i[c]) begin
                q_nxt = '0;
                upd   = 1'b1;
            end else if (load_i[c]) begin
                q_nxt = dval;
                upd   = 1'b1;
            end else if (en_i[c]) begin
                upd = 1'b1;
                if (down_i[c]) begin
                    evt   = (dlt > q_r);
                    q_nxt = (evt && (SATURATE != 0)) ? '0 : WIDTH'(q_r - dlt);
                end else begin
                    evt   = sum[WIDTH];
                    q_nxt = (evt && (SATURATE != 0)) ? '1 : sum[WIDTH-1:0];
                end
            end
            if (clear_i[c] || load_i[c]) begin
                ovf_nxt = 1'b0;
            end else if (evt) begin
                ovf_nxt = 1'b1;
            end else begin
                ovf_nxt = (STICKY_OVERFLOW != 0) && ovf_r;
            end
            match_nxt = upd && (q_nxt == cval);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q_r     <= '0;
                ovf_r   <= 1'b0;
                match_r <= 1'b0;
            end else begin
                q_r     <= q_nxt;
                ovf_r   <= ovf_nxt;
                match_r <= match_nxt;
            end
        end

        assign q_o[c*WIDTH +: WIDTH] = q_r;
        assign overflow_o[c]         = ovf_r;
        assign match_o[c]            = match_r;
    end

    assign any_overflow_o = |overflow_o;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: wrap, saturating and sticky-overflow instances
// driven with identical stimulus and checked against hand-computed vectors.
module tb_counter_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned NV  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] clear, load, en, down;
    logic [31:0]    delta, d, cmp;

    logic [31:0]    q_w, q_s, q_k;
    logic [NCH-1:0] ovf_w, ovf_s, ovf_k, m_w, m_s, m_k;
    logic           any_w, any_s, any_k;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic           rst;
        logic [NCH-1:0] clr;
        logic [NCH-1:0] ld;
        logic [NCH-1:0] en;
        logic [NCH-1:0] dn;
        logic [31:0]    delta;
        logic [31:0]    d;
        logic [31:0]    cmp;
        logic [31:0]    q_w;
        logic [31:0]    q_s;
        logic [NCH-1:0] ovf_w;
        logic [NCH-1:0] ovf_s;
        logic [NCH-1:0] ovf_k;
        logic [NCH-1:0] match;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(0), .STICKY_OVERFLOW(0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .load_i(load), .en_i(en), .down_i(down),
        .delta_i(delta), .d_i(d), .cmp_i(cmp),
        .q_o(q_w), .overflow_o(ovf_w), .match_o(m_w), .any_overflow_o(any_w));

    counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(1), .STICKY_OVERFLOW(0)) u_sat (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .load_i(load), .en_i(en), .down_i(down),
        .delta_i(delta), .d_i(d), .cmp_i(cmp),
        .q_o(q_s), .overflow_o(ovf_s), .match_o(m_s), .any_overflow_o(any_s));

    counter_bank #(.NUM_CH(NCH), .WIDTH(W), .SATURATE(0), .STICKY_OVERFLOW(1)) u_sticky (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .load_i(load), .en_i(en), .down_i(down),
        .delta_i(delta), .d_i(d), .cmp_i(cmp),
        .q_o(q_k), .overflow_o(ovf_k), .match_o(m_k), .any_overflow_o(any_k));

    // Build a vector touching ch0/ch1; ch2/ch3 stay idle with cmp=0xAA
    function automatic vec_t mk(input logic r, input logic [3:0] clr, ld, e, dn,
                                input logic [7:0] dl0, d0, cmp0, dl1, d1,
                                input logic [7:0] q0w, q0s, q1,
                                input logic [3:0] ow, os, ok, m);
        vec_t v;
        v.rst   = r;
        v.clr   = clr;
        v.ld    = ld;
        v.en    = e;
        v.dn    = dn;
        v.delta = {16'h0, dl1, dl0};
        v.d     = {16'h0, d1, d0};
        v.cmp   = {8'hAA, 8'hAA, 8'hAA, cmp0};
        v.q_w   = {16'h0, q1, q0w};
        v.q_s   = {16'h0, q1, q0s};
        v.ovf_w = ow;
        v.ovf_s = os;
        v.ovf_k = ok;
        v.match = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        rst   = v.rst;
        clear = v.clr;
        load  = v.ld;
        en    = v.en;
        down  = v.dn;
        delta = v.delta;
        d     = v.d;
        cmp   = v.cmp;
        @(posedge clk);
        #1;
        chk({tag, " q_wrap"},      q_w, v.q_w);
        chk({tag, " q_sat"},       q_s, v.q_s);
        chk({tag, " q_sticky"},    q_k, v.q_w);
        chk({tag, " ovf_wrap"},    32'(ovf_w), 32'(v.ovf_w));
        chk({tag, " ovf_sat"},     32'(ovf_s), 32'(v.ovf_s));
        chk({tag, " ovf_sticky"},  32'(ovf_k), 32'(v.ovf_k));
        chk({tag, " match_wrap"},  32'(m_w), 32'(v.match));
        chk({tag, " match_sat"},   32'(m_s), 32'(v.match));
        chk({tag, " match_sticky"}, 32'(m_k), 32'(v.match));
        chk({tag, " any_wrap"},    32'(any_w), 32'(|v.ovf_w));
        chk({tag, " any_sat"},     32'(any_s), 32'(|v.ovf_s));
        chk({tag, " any_sticky"},  32'(any_k), 32'(|v.ovf_k));
    endtask

    initial begin
        //              rst clr  ld    en    dn    dl0  d0   cmp0 dl1 d1   q0w  q0s  q1   ow  os  ok  m
        vecs[0]  = mk(0, 4'h0, 4'h3, 4'h0, 4'h0, 0,   250, 8'hAA, 0, 100, 250, 250, 100, 0, 0, 0, 0);
        vecs[1]  = mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 10,  0,   8'hAA, 0, 0,   4,   255, 100, 1, 1, 1, 0);
        vecs[2]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0,   0,   8'hAA, 0, 0,   4,   255, 100, 0, 0, 1, 0);
        vecs[3]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0,   0,   8'hAA, 0, 0,   4,   255, 100, 0, 0, 1, 0);
        vecs[4]  = mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 0,   7,   8'hAA, 0, 0,   7,   7,   100, 0, 0, 0, 0);
        vecs[5]  = mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 5,   0,   8'hAA, 0, 0,   2,   2,   100, 0, 0, 0, 0);
        vecs[6]  = mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 5,   0,   8'hAA, 0, 0,   253, 0,   100, 1, 1, 1, 0);
        vecs[7]  = mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 5,   0,   8'hAA, 0, 0,   248, 0,   100, 0, 1, 1, 0);
        vecs[8]  = mk(0, 4'h1, 4'h1, 4'h1, 4'h0, 1,   9,   8'hAA, 0, 0,   0,   0,   100, 0, 0, 0, 0);
        vecs[9]  = mk(0, 4'h0, 4'h1, 4'h1, 4'h0, 1,   9,   8'hAA, 0, 0,   9,   9,   100, 0, 0, 0, 0);
        vecs[10] = mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 0,   10,  8'd12, 0, 0,   10,  10,  100, 0, 0, 0, 0);
        vecs[11] = mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 2,   0,   8'd12, 0, 0,   12,  12,  100, 0, 0, 0, 1);
        vecs[12] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2,   0,   8'd12, 0, 0,   12,  12,  100, 0, 0, 0, 0);
        vecs[13] = mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 0,   0,   8'd12, 0, 0,   12,  12,  100, 0, 0, 0, 1);
        vecs[14] = mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 0,   255, 8'hAA, 0, 0,   255, 255, 100, 0, 0, 0, 0);
        vecs[15] = mk(0, 4'h0, 4'h0, 4'h3, 4'h0, 1,   0,   8'hAA, 5, 0,   0,   255, 105, 1, 1, 1, 0);

        // Reset state, with garbage on the other inputs
        apply("reset0", mk(1, 4'hF, 4'hF, 4'hF, 4'h0, 3, 9, 8'hAA, 3, 9, 0, 0, 0, 0, 0, 0, 0));
        apply("reset1", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < int'(NV); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Sticky flag must survive a run of hold cycles
        for (int i = 0; i < 5; i++)
            apply($sformatf("hold%0d", i),
                  mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'hAA, 0, 0, 0, 255, 105, 0, 0, 1, 0));

        // Reset mid-count with sticky overflow set, then count up from zero
        apply("rst_mid", mk(1, 4'h0, 4'h2, 4'h1, 4'h0, 3, 0, 8'hAA, 0, 50, 0, 0, 0, 0, 0, 0, 0));
        apply("post_rst", mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 3, 0, 8'hAA, 0, 0, 3, 3, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
